// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier (unsigned operands), one Booth digit per cycle.
// Optional macro BOOTH_SEQ_EARLY_TERM_EN ends RUN once the remaining multiplier bits are zero.
module booth_seq_mul #(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16,
  parameter int COUNT   = (WIDTH_B + 2) / 2,
  parameter int WIDTH_O = WIDTH_A + WIDTH_B
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH_A-1:0] operand_a_i,
  input  logic [WIDTH_B-1:0] operand_b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH_O-1:0] product_o,
  output logic               busy_o
);

  localparam int MW = WIDTH_A + 1;
  localparam int XW = WIDTH_B + 3;
  localparam int CW = $clog2(COUNT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH_A-1:0] a_q;
  logic [XW-1:0]      b_q;
  logic [WIDTH_O-1:0] acc_q, acc_d, product_q;
  logic [CW-1:0]      cnt_q;
  logic               sign_q;
  logic [CW:0]        sh;
  logic [2:0]         digit;
  logic               neg;
  logic               last;
  logic [MW-1:0]      mag, row_bits;
  logic [WIDTH_O-1:0] row_term, inj_term, close_term;

  // b_q shifts right two bits per digit, so the current digit always sits in b_q[2:0].
  always_comb begin
    sh    = {cnt_q, 1'b0};
    digit = b_q[2:0];
    mag   = '0;
    neg   = 1'b0;
    case (digit)
      3'b001, 3'b010: mag = {1'b0, a_q};
      3'b011:         mag = {a_q, 1'b0};
      3'b100: begin
        mag = {a_q, 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = {1'b0, a_q};
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    row_bits = neg ? ~mag : mag;

    // Rows carry sign-extension constants; the closing term removes what the unprocessed rows would have cancelled.
    if (cnt_q == '0) begin
      row_term = WIDTH_O'({~neg, neg, neg, row_bits});
    end else begin
      row_term = WIDTH_O'({1'b1, ~neg, row_bits}) << sh;
    end
    inj_term = (WIDTH_O'(sign_q) << sh) >> 2;

`ifdef BOOTH_SEQ_EARLY_TERM_EN
    last = (cnt_q == CW'(COUNT - 1)) || (b_q[XW-1:2] == '0);
`else
    last = (cnt_q == CW'(COUNT - 1));
`endif

    close_term = '0;
    if (last) begin
      close_term = (WIDTH_O'(neg) << sh) - ((WIDTH_O'(1'b1) << (MW + 2)) << sh);
    end
    acc_d = acc_q + row_term + inj_term + close_term;
  end

  always_comb begin
    state_next  = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_next = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid_i) begin
        a_q    <= operand_a_i;
        b_q    <= {2'b00, operand_b_i, 1'b0};
        acc_q  <= '0;
        cnt_q  <= '0;
        sign_q <= 1'b0;
      end else if (state == RUN) begin
        acc_q  <= acc_d;
        b_q    <= b_q >> 2;
        cnt_q  <= cnt_q + CW'(1);
        sign_q <= neg;
        if (last) product_q <= acc_d;
      end
    end
  end

  assign product_o = product_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed bench for booth_seq_mul (16x16): products, latency, stall hold, reset abort.
module tb_booth_seq_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] op_a, op_b;
  logic [31:0] product;
  int          checks = 0;
  int          errors = 0;

  booth_seq_mul dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .operand_a_i(op_a),
    .operand_b_i(op_b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .product_o  (product),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Handshake-to-valid latency, counting the handshake cycle as cycle 1.
  function automatic int expLatency(input logic [15:0] b);
    int k;
    logic [18:0] ext;
    ext = {2'b00, b, 1'b0};
    k = 9;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    k = 1;
    while (k < 9 && (ext >> (2 * k)) != 19'd0) k++;
`endif
    return k + 1;
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input int gap);
    int w;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    checkOutput("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = 16'($urandom);
    op_b = 16'($urandom);
  endtask

  task automatic collect(input string tag, input logic [31:0] exp_prod, input int exp_lat, input int stall);
    int lat;
    lat = 1;
    out_ready = (stall == 0);
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_prod"}, product, exp_prod);
    checkOutput({tag, "_lat"}, lat, exp_lat);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_prod"}, product, exp_prod);
      checkOutput({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_ack_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_ack_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [15:0] vec_a [8] = '{16'hFFFF, 16'h0001, 16'hAAAA, 16'h8000, 16'hFFFF, 16'h1234, 16'h0000, 16'h0003};
  logic [15:0] vec_b [8] = '{16'h0001, 16'hFFFF, 16'h5555, 16'h8000, 16'h8000, 16'h5678, 16'h0000, 16'h0005};
  logic [31:0] vec_p [8] = '{32'h0000FFFF, 32'h0000FFFF, 32'd954408050, 32'h40000000,
                             32'h7FFF8000, 32'd103153760, 32'h00000000, 32'd15};

  initial begin
    int seen;
    logic [15:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_product", product, 32'd0);

    applyStimulus(16'hFFFF, 16'hFFFF, 0);
    checkOutput("run_busy", {31'd0, busy}, 32'd1);
    checkOutput("run_in_ready", {31'd0, in_ready}, 32'd0);
    collect("ffff_x_ffff", 32'hFFFE0001, expLatency(16'hFFFF), 0);

    applyStimulus(16'h1234, 16'h0000, 1);
    collect("b_zero", 32'h00000000, expLatency(16'h0000), 0);

    applyStimulus(16'h8000, 16'h0003, 0);
    collect("stall", 32'h00018000, expLatency(16'h0003), 5);

    applyStimulus(16'd7, 16'd9, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_product", product, 32'd0);
    seen = 0;
    repeat (15) begin @(posedge clk); #1; seen += int'(out_valid); end
    checkOutput("abort_no_valid", seen, 0);
    applyStimulus(16'd3, 16'd5, 0);
    collect("after_abort", 32'd15, expLatency(16'd5), 0);

    in_valid = 1'b1; op_a = 16'd2; op_b = 16'd2; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("rst_prio_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_prio_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vec_a[i], vec_b[i], i % 3);
      collect("vec", vec_p[i], expLatency(vec_b[i]), i % 2);
    end

    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = (i % 7 == 0) ? 16'(ra >> (i % 16)) : 16'($urandom);
      applyStimulus(ra, rb, $urandom_range(0, 3));
      collect("rand", {16'd0, ra} * {16'd0, rb}, expLatency(rb), $urandom_range(0, 3));
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
